ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Parametrised PS/2 host-to-device command transmitter for the keyboard FPGA. Performs the full request-to-send sequence, then shifts an arbitrary byte LSB-first with odd parity on device-generated clock edges. It checks the device ACK and enforces a watchdog timeout. Sits between the keyboard controller logic (reset 0xFF, LED 0xED, enable 0xF4, ...) and the open-drain PS/2 pad pulldowns.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before data pulldown (>=100 us at system clock)
START_HOLD_CYCLES, 50, clk cycles both lines held low before ps2_clk release
TIMEOUT_CYCLES, 100000, max clk cycles between consecutive ps2_clk falling edges (and from clk release to first edge)
CNT_WIDTH, 17, width of shared cycle counter; must hold max(INHIBIT_CYCLES, START_HOLD_CYCLES, TIMEOUT_CYCLES)
SYNC_STAGES, 2, synchroniser flops on ps2_clk_in/ps2_data_in (>=2)

Ports:
clk  input  1  system clock
reset_required  input  1  asynchronous, active-high reset
cmd_valid  input  1  command byte offered
cmd_data  input  8  byte to send
cmd_ready  output  1  high only in IDLE; handshake when cmd_valid && cmd_ready
abort  input  1  synchronous abort of frame in progress
ps2_clk_in  input  1  raw PS/2 clock pad level
ps2_data_in  input  1  raw PS/2 data pad level
ps2_clk_pulldown  output  1  1 = drive PS/2 clock low
ps2_data_pulldown  output  1  1 = drive PS/2 data low
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse: frame completed and lines released
ack_ok  output  1  valid with done; 1 = device ACK (data low at edge 11)
timeout_err  output  1  one-cycle pulse: watchdog expired, frame abandoned

Behaviour:
- Reset (async): state IDLE; all pulldowns 0; done/ack_ok/timeout_err 0; busy 0; cmd_ready 1; counters and shift register cleared. Lines released in the same instant as reset assertion, mid-frame included.
- All outputs registered except cmd_ready/busy, which are decoded from state.
- Inputs synchronised (SYNC_STAGES); fall = synced clk previous 1, now 0. Edge latency SYNC_STAGES+1 cycles.
- IDLE: on handshake, latch cmd_data, compute parity = ~^cmd_data, load 11-bit frame, clear counter; next cycle INHIBIT with clk_pulldown=1.
- INHIBIT: count to INHIBIT_CYCLES; on reaching it, data_pulldown=1 (start bit), counter clear -> START.
- START: both low; after START_HOLD_CYCLES, clk_pulldown=0, edge_cnt=0, counter clear -> SHIFT.
- SHIFT, on each fall (edge_cnt++ first):
  - edges 1-8: data_pulldown = ~data[edge-1];
  - edge 9: data_pulldown = ~parity;
  - edge 10: data_pulldown = 0 (stop) -> ACK.
- ACK: on fall (edge 11) sample synced data; ack_ok_reg = ~data -> WAIT_IDLE.
- WAIT_IDLE: when synced clk and data both 1 -> IDLE, done=1, ack_ok=ack_ok_reg for that cycle. NAK (data high at edge 11) still produces done with ack_ok=0.
- Watchdog: in SHIFT/ACK/WAIT_IDLE counter restarts on each fall; reaching TIMEOUT_CYCLES -> both pulldowns 0, timeout_err pulse, IDLE, no done.
- abort in any non-IDLE state: next cycle pulldowns 0, IDLE, no done/timeout_err. abort in IDLE: ignored. abort and timeout in same cycle: abort wins (no pulse).
- cmd_valid while busy: not accepted, held by requester.
- Counter saturates; never wraps.
- Fall edges in IDLE/INHIBIT/START are ignored (device-to-host traffic is handled by the receiver).

Decomposition:
- Package ps2_pkg: state enum (IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE), constants PS2_DATA_BITS=8, PS2_PARITY_EDGE=9, PS2_STOP_EDGE=10, PS2_ACK_EDGE=11, the command codes 0xFF/0xED/0xF4/0xAA shared with the receiver.
- One sub-module: ps2_edge_sync (SYNC_STAGES synchroniser on clk and data plus falling-edge pulse), reused by the receiver.

Test Plan (INHIBIT_CYCLES=20, START_HOLD_CYCLES=4, TIMEOUT_CYCLES=200):
- Send 0xFF; device model clocks 11 edges, pulls data low at edge 11 -> clk low for 20 cycles; observed bits 1111_1111, parity 1, stop 1; done=1, ack_ok=1; cmd_ready returns 1.
- Send 0xF4 -> bits 0,0,1,0,1,1,1,1 LSB-first; parity 0 (data_pulldown=1 during parity); done with ack_ok=1.
- Send 0xED, device leaves data high at edge 11 -> done=1, ack_ok=0, lines released.
- Device stops after edge 5 -> exactly 200 cycles later timeout_err=1, both pulldowns 0, busy 0, no done.
- Assert reset_required after edge 3 -> pulldowns 0 immediately (asynchronous); post-release state IDLE; a new 0xFF frame completes normally.
- abort during INHIBIT at cycle 10; cmd_valid held during busy -> lines released next cycle, no done; the second command is accepted only after IDLE and is sent intact.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame edge numbering,
// and the command/response codes used by both the transmitter and receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int unsigned PS2_DATA_BITS   = 8;
  localparam int unsigned PS2_PARITY_EDGE = 9;
  localparam int unsigned PS2_STOP_EDGE   = 10;
  localparam int unsigned PS2_ACK_EDGE    = 11;
  localparam int unsigned PS2_FRAME_BITS  = 11;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

  // Frame bit n is what the line must carry after falling edge n;
  // bit 0 is the start bit driven before the clock is released.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_build_frame(
    input logic [PS2_DATA_BITS-1:0] d
  );
    return {1'b1, ps2_odd_parity(d), d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Synchronises the raw PS/2 clock and data pads into the system clock
// domain and produces a single-cycle pulse on each PS/2 clock falling edge.
module ps2_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_required,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic clk_fall_o
);

  logic [SYNC_STAGES-1:0] clk_sr_q;
  logic [SYNC_STAGES-1:0] data_sr_q;
  logic                   clk_prev_q;

  // Shift chains reset to the idle (released, high) level so that leaving
  // reset never fabricates a falling edge.
  always_ff @(posedge clk or posedge reset_required) begin
    if (reset_required) begin
      clk_sr_q   <= '1;
      data_sr_q  <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sr_q   <= {clk_sr_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sr_q  <= {data_sr_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q <= clk_sr_q[SYNC_STAGES-1];
    end
  end

  assign clk_sync_o  = clk_sr_q[SYNC_STAGES-1];
  assign data_sync_o = data_sr_q[SYNC_STAGES-1];
  assign clk_fall_o  = clk_prev_q & ~clk_sr_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, LSB-first byte
// with odd parity on device clock falls, ACK check and inter-edge watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES    = 5000,
  parameter int unsigned START_HOLD_CYCLES = 50,
  parameter int unsigned TIMEOUT_CYCLES    = 100000,
  parameter int unsigned CNT_WIDTH         = 17,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic       clk,
  input  logic       reset_required,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       abort,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_pulldown,
  output logic       ps2_data_pulldown,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout_err
);

  localparam logic [CNT_WIDTH-1:0] INHIBIT_LAST = CNT_WIDTH'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] START_LAST   = CNT_WIDTH'(START_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  ps2_state_e                  state_q;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic [CNT_WIDTH-1:0]        cnt_inc;
  logic [3:0]                  edge_q;
  logic [3:0]                  edge_nxt;
  logic [PS2_FRAME_BITS-1:0]   frame_q;
  logic                        ack_seen_q;
  logic                        clk_pd_q;
  logic                        data_pd_q;
  logic                        done_q;
  logic                        ack_ok_q;
  logic                        timeout_q;

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  ps2_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk           (clk),
    .reset_required(reset_required),
    .ps2_clk_i     (ps2_clk_in),
    .ps2_data_i    (ps2_data_in),
    .clk_sync_o    (clk_sync),
    .data_sync_o   (data_sync),
    .clk_fall_o    (clk_fall)
  );

  // Shared cycle counter saturates at all-ones instead of wrapping.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign edge_nxt = edge_q + 4'd1;

  // Transmit sequencer; abort outranks every other transition including timeout.
  always_ff @(posedge clk or posedge reset_required) begin
    if (reset_required) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      frame_q    <= '0;
      ack_seen_q <= 1'b0;
      clk_pd_q   <= 1'b0;
      data_pd_q  <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      timeout_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q   <= IDLE;
        clk_pd_q  <= 1'b0;
        data_pd_q <= 1'b0;
        cnt_q     <= '0;
        edge_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cmd_valid) begin
              frame_q    <= ps2_build_frame(cmd_data);
              ack_seen_q <= 1'b0;
              cnt_q      <= '0;
              clk_pd_q   <= 1'b1;
              data_pd_q  <= 1'b0;
              state_q    <= INHIBIT;
            end
          end

          INHIBIT: begin
            if (cnt_q == INHIBIT_LAST) begin
              data_pd_q <= ~frame_q[0];
              cnt_q     <= '0;
              state_q   <= START;
            end else begin
              cnt_q <= cnt_inc;
            end
          end

          START: begin
            if (cnt_q == START_LAST) begin
              clk_pd_q <= 1'b0;
              edge_q   <= '0;
              cnt_q    <= '0;
              state_q  <= SHIFT;
            end else begin
              cnt_q <= cnt_inc;
            end
          end

          SHIFT: begin
            if (clk_fall) begin
              edge_q    <= edge_nxt;
              cnt_q     <= '0;
              data_pd_q <= ~frame_q[edge_nxt];
              if (edge_nxt == 4'(PS2_STOP_EDGE)) begin
                state_q <= ACK;
              end
            end else if (cnt_q == TIMEOUT_LAST) begin
              clk_pd_q  <= 1'b0;
              data_pd_q <= 1'b0;
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= IDLE;
            end else begin
              cnt_q <= cnt_inc;
            end
          end

          ACK: begin
            if (clk_fall) begin
              edge_q     <= edge_nxt;
              ack_seen_q <= ~data_sync;
              cnt_q      <= '0;
              state_q    <= WAIT_IDLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
              clk_pd_q  <= 1'b0;
              data_pd_q <= 1'b0;
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= IDLE;
            end else begin
              cnt_q <= cnt_inc;
            end
          end

          WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
              done_q   <= 1'b1;
              ack_ok_q <= ack_seen_q;
              cnt_q    <= '0;
              state_q  <= IDLE;
            end else if (clk_fall) begin
              cnt_q <= '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
              clk_pd_q  <= 1'b0;
              data_pd_q <= 1'b0;
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= IDLE;
            end else begin
              cnt_q <= cnt_inc;
            end
          end

          default: begin
            clk_pd_q  <= 1'b0;
            data_pd_q <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_ready         = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign ps2_clk_pulldown  = clk_pd_q;
  assign ps2_data_pulldown = data_pd_q;
  assign done              = done_q;
  assign ack_ok            = ack_ok_q;
  assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device on the bus.
module tb_ps2_host_tx;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset_required = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       abort = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       cmd_ready, ps2_clk_pulldown, ps2_data_pulldown;
  logic       busy, done, ack_ok, timeout_err;
  logic       ps2_clk_line, ps2_data_line;

  // Open-drain bus: either side may pull low.
  assign ps2_clk_line  = dev_clk  & ~ps2_clk_pulldown;
  assign ps2_data_line = dev_data & ~ps2_data_pulldown;

  ps2_host_tx #(
    .INHIBIT_CYCLES   (20),
    .START_HOLD_CYCLES(4),
    .TIMEOUT_CYCLES   (200),
    .CNT_WIDTH        (17),
    .SYNC_STAGES      (2)
  ) dut (
    .clk              (clk),
    .reset_required   (reset_required),
    .cmd_valid        (cmd_valid),
    .cmd_data         (cmd_data),
    .cmd_ready        (cmd_ready),
    .abort            (abort),
    .ps2_clk_in       (ps2_clk_line),
    .ps2_data_in      (ps2_data_line),
    .ps2_clk_pulldown (ps2_clk_pulldown),
    .ps2_data_pulldown(ps2_data_pulldown),
    .busy             (busy),
    .done             (done),
    .ack_ok           (ack_ok),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       is_to;
    logic       ack;
    logic [9:0] bits;   // {stop, parity, data[7:0]} as seen on the line
  } exp_t;

  exp_t        exp_q[$];
  logic [9:0]  dev_bits = '0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: pops an expectation on every done / timeout_err pulse and
  // also measures the inhibit / start-hold phase lengths and timeout latency.
  initial begin : monitor
    exp_t        e;
    int unsigned inh_run = 0;
    int unsigned both_run = 0;
    int unsigned last_fall_cyc = 0;
    logic        prev_dpd = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_required) begin
        inh_run = 0; both_run = 0; prev_dpd = 1'b0;
      end else begin
        if (ps2_clk_pulldown && !ps2_data_pulldown) inh_run++;
        else if (ps2_clk_pulldown && ps2_data_pulldown) both_run++;
        else begin
          if (both_run > 0) begin
            check("inhibit_len", inh_run, 20);
            check("start_hold_len", both_run, 4);
          end
          inh_run = 0; both_run = 0;
        end
        if (prev_dpd && !ps2_data_pulldown) last_fall_cyc = cyc;
        prev_dpd = ps2_data_pulldown;

        if (done || timeout_err) begin
          if (exp_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_pulse: got done=%0b timeout_err=%0b want none", done, timeout_err);
          end else begin
            e = exp_q.pop_front();
            check("pulse_kind", {done, timeout_err}, e.is_to ? 2'b01 : 2'b10);
            check("released_idle", {ps2_clk_pulldown, ps2_data_pulldown, busy, cmd_ready}, 4'b0001);
            if (e.is_to) begin
              check("timeout_latency", cyc - last_fall_cyc, 200);
            end else begin
              check("ack_ok", ack_ok, e.ack);
              check("frame_bits", dev_bits, e.bits);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int unsigned n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 500) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    check("cmd_accepted_busy", busy, 1);
    cmd_valid = 1'b0;
  endtask

  // Device: waits for request-to-send, then clocks n_edges falls, sampling
  // the line just before each rise; pulls data low for edge 11 if give_ack.
  task automatic device_run(input int n_edges, input bit give_ack);
    int unsigned n = 0;
    dev_bits = '0;
    while (!(!ps2_clk_pulldown && ps2_data_pulldown) && n < 300) begin
      @(negedge clk); n++;
    end
    check("request_to_send", {ps2_clk_pulldown, ps2_data_pulldown}, 2'b01);
    repeat (HALF) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (e <= 10) dev_bits[e-1] = ps2_data_line;
      dev_clk = 1'b1;
      if (e == 10 && give_ack) dev_data = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    check("scoreboard_drain", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {ps2_clk_pulldown, ps2_data_pulldown, busy, cmd_ready, done, ack_ok, timeout_err},
          7'b0001000);
    reset_required = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, cmd_ready, ps2_clk_pulldown}, 3'b010);

    // 0xFF, ACK: bits 1111_1111, parity 1, stop 1
    exp_q.push_back(exp_t'{1'b0, 1'b1, 10'h3FF});
    send(8'hFF);
    device_run(11, 1'b1);
    wait_drain(100);

    // 0xF4, ACK: parity 0 -> 10'b1_0_1111_0100
    exp_q.push_back(exp_t'{1'b0, 1'b1, 10'h2F4});
    send(8'hF4);
    device_run(11, 1'b1);
    wait_drain(100);

    // 0xED, NAK: parity 1 -> 10'b1_1_1110_1101
    exp_q.push_back(exp_t'{1'b0, 1'b0, 10'h3ED});
    send(8'hED);
    device_run(11, 1'b0);
    wait_drain(100);

    // Device stalls after edge 5 (0x10: bit4 releases data at edge 5)
    exp_q.push_back(exp_t'{1'b1, 1'b0, 10'h000});
    send(8'h10);
    device_run(5, 1'b0);
    wait_drain(400);

    // Asynchronous reset mid-frame, then a clean 0xFF frame
    send(8'h00);
    device_run(3, 1'b0);
    check("pre_reset_data_pd", ps2_data_pulldown, 1);
    #3 reset_required = 1'b1;
    #1 check("async_release", {ps2_clk_pulldown, ps2_data_pulldown, busy}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    reset_required = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {busy, cmd_ready}, 2'b01);
    exp_q.push_back(exp_t'{1'b0, 1'b1, 10'h3FF});
    send(8'hFF);
    device_run(11, 1'b1);
    wait_drain(100);

    // Abort in INHIBIT while a second command is held on cmd_valid
    send(8'h55);
    exp_q.push_back(exp_t'{1'b0, 1'b1, 10'h2F4});
    cmd_data  = 8'hF4;
    cmd_valid = 1'b1;
    repeat (9) @(negedge clk);
    check("held_not_accepted", {cmd_ready, ps2_clk_pulldown, ps2_data_pulldown}, 3'b010);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_release", {ps2_clk_pulldown, ps2_data_pulldown, busy, cmd_ready, done, timeout_err},
          6'b000100);
    @(negedge clk);
    check("held_cmd_accepted", busy, 1);
    cmd_valid = 1'b0;
    device_run(11, 1'b1);
    wait_drain(100);

    repeat (20) @(negedge clk);
    check("no_stray_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
